// File: rtl/nn_pkg.sv
// nn_pkg: shared types and constants for the neural-net frame driver slice.
//   fix_t       signed 32-bit Q16.16 value used on both nn_inputs and nn_outputs
//   state_e     frame driver FSM states
//   pix_to_fix  unsigned pixel -> Q16.16 (pixel lands just below the binary point)
package nn_pkg;

  typedef logic signed [31:0] fix_t;

  localparam int FIX_W      = 32;
  localparam int FRAC_BITS  = 16;
  localparam int PIX_W      = 8;
  localparam int N_IN_DEF   = 784;
  localparam int N_OUT_DEF  = 10;
  localparam int SETTLE_DEF = 4;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    SCAN   = 2'd2,
    DONE   = 2'd3
  } state_e;

  // 255 -> 32'h0000_FF00: the pixel is scaled to [0, 1) in Q16.16.
  function automatic fix_t pix_to_fix(input logic [PIX_W-1:0] p);
    fix_t f;
    f = '0;
    f[PIX_W-1:0] = p;
    return fix_t'(f << (FRAC_BITS - PIX_W));
  endfunction

endpackage

// File: rtl/nn_frame_driver_seq_argmax.sv
// seq_argmax: sequential argmax over a stream of signed scores, one per cycle.
//   clk, rst_n  clock, asynchronous active-low reset
//   start       marks the first score of a scan (unconditionally loaded)
//   valid       a score is presented this cycle
//   last        the presented score is the final one of the scan
//   idx         index of the presented score
//   score       signed Q16.16 score
//   done        one-cycle pulse the cycle after the last score was taken
//   best_idx    index of the highest score (lowest index wins ties)
//   best_val    value of the highest score
module seq_argmax
  import nn_pkg::*;
#(
  parameter int KW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              valid,
  input  logic              last,
  input  logic [KW-1:0]     idx,
  input  logic signed [31:0] score,
  output logic              done,
  output logic [KW-1:0]     best_idx,
  output logic signed [31:0] best_val
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= 1'b0;
      best_idx <= '0;
      best_val <= '0;
    end else begin
      done <= valid && last;
      // Strict greater-than keeps the earliest index on ties.
      if (valid && (start || (score > best_val))) begin
        best_idx <= idx;
        best_val <= score;
      end
    end
  end

endmodule

// File: rtl/nn_frame_driver.sv
// nn_frame_driver: loads a pixel frame into the neural_net input vector, waits for
// the combinational net to settle, scans its scores with a sequential argmax and
// presents the winning digit on a result handshake.
//   clk, rst_n  clock, asynchronous active-low reset
//   s_valid/s_ready/s_data/s_last  pixel stream (beat moves when s_valid && s_ready)
//   nn_inputs   flattened N_IN x Q16.16 input vector (word i at [32*i +: 32])
//   nn_outputs  flattened N_OUT x signed Q16.16 scores (word k at [32*k +: 32])
//   res_valid/res_ready  result handshake (result moves when both are high;
//               res_digit/res_score stay stable while res_valid waits)
//   res_digit   index of the highest score, res_score its value
//   frame_err   one-cycle pulse when s_last disagrees with the frame length
//   dbg_state   current FSM state (nn_pkg::state_e encoding)
module nn_frame_driver
  import nn_pkg::*;
#(
  parameter int N_IN          = N_IN_DEF,
  parameter int N_OUT         = N_OUT_DEF,
  parameter int SETTLE_CYCLES = SETTLE_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [PIX_W-1:0]       s_data,
  input  logic                   s_last,
  output logic [32*N_IN-1:0]     nn_inputs,
  input  logic [32*N_OUT-1:0]    nn_outputs,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [3:0]             res_digit,
  output logic [31:0]            res_score,
  output logic                   frame_err,
  output logic [1:0]             dbg_state
);

  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int KW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  state_e         state_q, state_d;
  logic           s_ready_q;
  logic           frame_err_q;
  logic [IW-1:0]  idx_q;
  logic [SW-1:0]  settle_q;
  logic [KW-1:0]  k_q;
  logic           scan_fin_q;
  fix_t           in_q [N_IN];
  fix_t           score_arr [N_OUT];

  logic           accept;
  logic           last_pix;
  logic           settle_end;
  logic           scan_sample;
  logic           scan_last;
  logic           am_done;
  logic [KW-1:0]  am_idx;
  fix_t           am_val;
  logic [3:0]     digit_ext;

  assign accept      = s_valid && s_ready_q && (state_q == LOAD);
  assign last_pix    = (idx_q == IW'(N_IN - 1));
  assign settle_end  = (settle_q == SW'(SETTLE_CYCLES - 1));
  assign scan_sample = (state_q == SCAN) && !scan_fin_q;
  assign scan_last   = (k_q == KW'(N_OUT - 1));

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (accept && last_pix) state_d = SETTLE;
      SETTLE:  if (settle_end)         state_d = SCAN;
      SCAN:    if (am_done)            state_d = DONE;
      DONE:    if (res_ready)          state_d = LOAD;
      default:                         state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;
  end

  // Control registers. s_ready is registered from the next state so it is 0
  // during reset, rises one edge after release, and drops on the edge that
  // takes the final beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready_q   <= 1'b0;
      frame_err_q <= 1'b0;
      idx_q       <= '0;
      settle_q    <= '0;
      k_q         <= '0;
      scan_fin_q  <= 1'b0;
    end else begin
      s_ready_q   <= (state_d == LOAD);
      frame_err_q <= accept && (last_pix != s_last);

      // A short frame (s_last early) rewinds the index and is discarded.
      if (accept) begin
        if (last_pix || s_last) idx_q <= '0;
        else                    idx_q <= idx_q + IW'(1);
      end

      if (state_q == SETTLE) settle_q <= settle_q + SW'(1);
      else                   settle_q <= '0;

      // k stops at N_OUT-1; scan_fin blocks further samples while the
      // argmax result registers.
      if (state_q == SCAN) begin
        if (!scan_fin_q) begin
          if (scan_last) scan_fin_q <= 1'b1;
          else           k_q        <= k_q + KW'(1);
        end
      end else begin
        k_q        <= '0;
        scan_fin_q <= 1'b0;
      end
    end
  end

  // Input vector: written only on accepted beats, so it stays frozen from the
  // final beat through SETTLE, SCAN and DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) in_q[i] <= '0;
    end else if (accept) begin
      in_q[idx_q] <= pix_to_fix(s_data);
    end
  end

  for (genvar g = 0; g < N_IN; g++) begin : g_in
    assign nn_inputs[32*g +: 32] = in_q[g];
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_out
    assign score_arr[g] = nn_outputs[32*g +: 32];
  end

  seq_argmax #(.KW(KW)) u_argmax (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (k_q == '0),
    .valid    (scan_sample),
    .last     (scan_last),
    .idx      (k_q),
    .score    (score_arr[k_q]),
    .done     (am_done),
    .best_idx (am_idx),
    .best_val (am_val)
  );

  always_comb begin
    digit_ext = '0;
    digit_ext[KW-1:0] = am_idx;
  end

  assign s_ready   = s_ready_q;
  assign res_valid = (state_q == DONE);
  assign res_digit = digit_ext;
  assign res_score = am_val;
  assign frame_err = frame_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_nn_frame_driver.sv
// Directed bench for nn_frame_driver: the bench plays neural_net by driving
// fixed score vectors, streams frames and checks results against hand values.
module tb_nn_frame_driver;
  import nn_pkg::*;

  localparam int NI = 784;
  localparam int NO = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [7:0]        s_data;
  logic              s_last;
  logic [32*NI-1:0]  nn_inputs;
  logic [32*NO-1:0]  nn_outputs;
  logic              res_valid;
  logic              res_ready;
  logic [3:0]        res_digit;
  logic [31:0]       res_score;
  logic              frame_err;
  logic [1:0]        dbg_state;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int cyc      = 0;
  int err_cnt  = 0;
  int acc_cyc  = 0;

  nn_frame_driver dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .nn_inputs(nn_inputs), .nn_outputs(nn_outputs),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_digit(res_digit), .res_score(res_score),
    .frame_err(frame_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / monitors ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (frame_err) err_cnt++;

  // ---------------- driver tasks ----------------
  function automatic logic [7:0] pix(input int mode, input int i);
    case (mode)
      0:       return 8'hFF;
      1:       return 8'(i);
      default: return 8'h11;
    endcase
  endfunction

  task automatic set_score(input int k, input logic [31:0] v);
    nn_outputs[32*k +: 32] = v;
  endtask

  // Presents one beat at a negedge and returns at the negedge after it is taken.
  task automatic push_beat(input logic [7:0] d, input logic last, input int gap);
    int n;
    repeat (gap) begin
      s_valid = 1'b0; s_data = 8'($urandom); s_last = 1'($urandom);
      @(negedge clk);
    end
    s_valid = 1'b1; s_data = d; s_last = last; n = 0;
    while (!s_ready && n < 200) begin @(negedge clk); n++; end
    if (!s_ready) begin
      tot_cnt++;
      $display("FAIL beat_timeout s_ready=%0b required 1", s_ready);
    end
    acc_cyc = cyc + 1;
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input int n, input int last_at, input int mode, input int maxgap);
    for (int i = 0; i < n; i++)
      push_beat(pix(mode, i), (i == last_at), (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
  endtask

  task automatic wait_res(output int lat);
    int n;
    n = 0;
    while (!res_valid && n < 100) begin @(negedge clk); n++; end
    lat = res_valid ? (cyc - acc_cyc) : -1;
  endtask

  function automatic int count_bad(input int mode, input int upto);
    int bad;
    logic [31:0] e;
    bad = 0;
    for (int i = 0; i < upto; i++) begin
      e = {16'h0000, pix(mode, i), 8'h00};
      if (nn_inputs[32*i +: 32] !== e) bad++;
    end
    return bad;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; res_ready = 1'b1;
    nn_outputs = '0;
    repeat (3) @(negedge clk);
    tot_cnt++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready got %0b exp 0", s_ready); else pass_cnt++;
    tot_cnt++; if (res_valid !== 1'b0 || frame_err !== 1'b0) $display("FAIL rst_flags got %0b%0b exp 00", res_valid, frame_err); else pass_cnt++;
    tot_cnt++; if (res_digit !== 4'd0 || res_score !== 32'd0) $display("FAIL rst_result got %0d/%h exp 0/0", res_digit, res_score); else pass_cnt++;
    tot_cnt++; if (nn_inputs !== '0) $display("FAIL rst_inputs got nonzero exp 0"); else pass_cnt++;
    tot_cnt++; if (dbg_state !== 2'(LOAD)) $display("FAIL rst_state got %0d exp %0d", dbg_state, LOAD); else pass_cnt++;
    rst_n = 1'b1;
    #1;
    tot_cnt++; if (s_ready !== 1'b0) $display("FAIL rel_s_ready_early got %0b exp 0", s_ready); else pass_cnt++;
    @(negedge clk);
    tot_cnt++; if (s_ready !== 1'b1) $display("FAIL rel_s_ready got %0b exp 1", s_ready); else pass_cnt++;
  endtask

  task automatic test_basic();
    int lat;
    nn_outputs = '0;
    set_score(3, 32'h0002_0000);
    send_frame(NI, NI-1, 0, 0);
    tot_cnt++; if (dbg_state !== 2'(SETTLE)) $display("FAIL basic_settle got %0d exp %0d", dbg_state, SETTLE); else pass_cnt++;
    tot_cnt++; if (s_ready !== 1'b0) $display("FAIL basic_settle_ready got %0b exp 0", s_ready); else pass_cnt++;
    wait_res(lat);
    tot_cnt++; if (lat !== 15) $display("FAIL basic_latency got %0d exp 15", lat); else pass_cnt++;
    tot_cnt++; if (count_bad(0, NI) !== 0) $display("FAIL basic_inputs bad_words=%0d exp 0", count_bad(0, NI)); else pass_cnt++;
    tot_cnt++; if (res_digit !== 4'd3) $display("FAIL basic_digit got %0d exp 3", res_digit); else pass_cnt++;
    tot_cnt++; if (res_score !== 32'h0002_0000) $display("FAIL basic_score got %h exp 00020000", res_score); else pass_cnt++;
    @(negedge clk);
    tot_cnt++; if (res_valid !== 1'b0 || s_ready !== 1'b1) $display("FAIL basic_taken got v=%0b r=%0b exp v=0 r=1", res_valid, s_ready); else pass_cnt++;
    tot_cnt++; if (err_cnt !== 0) $display("FAIL basic_no_err got %0d exp 0", err_cnt); else pass_cnt++;
  endtask

  task automatic test_ties();
    int lat;
    for (int k = 0; k < NO; k++) set_score(k, 32'hFFFF_8000);
    set_score(2, 32'h0001_0000);
    set_score(7, 32'h0001_0000);
    send_frame(NI, NI-1, 1, 0);
    wait_res(lat);
    tot_cnt++; if (lat !== 15) $display("FAIL ties_latency got %0d exp 15", lat); else pass_cnt++;
    tot_cnt++; if (res_digit !== 4'd2) $display("FAIL ties_digit got %0d exp 2", res_digit); else pass_cnt++;
    tot_cnt++; if (res_score !== 32'h0001_0000) $display("FAIL ties_score got %h exp 00010000", res_score); else pass_cnt++;
    tot_cnt++; if (count_bad(1, NI) !== 0) $display("FAIL ties_inputs bad_words=%0d exp 0", count_bad(1, NI)); else pass_cnt++;
    tot_cnt++; if (nn_inputs[32*783 +: 32] !== 32'h0000_0F00) $display("FAIL ties_last_word got %h exp 00000F00", nn_inputs[32*783 +: 32]); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_negative();
    int lat;
    for (int k = 0; k < NO; k++) set_score(k, -((k + 1) << 16));
    send_frame(NI, NI-1, 1, 0);
    wait_res(lat);
    tot_cnt++; if (lat !== 15) $display("FAIL neg_latency got %0d exp 15", lat); else pass_cnt++;
    tot_cnt++; if (res_digit !== 4'd0) $display("FAIL neg_digit got %0d exp 0", res_digit); else pass_cnt++;
    tot_cnt++; if (res_score !== 32'hFFFF_0000) $display("FAIL neg_score got %h exp FFFF0000", res_score); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_frame_err();
    int lat;
    int e0;
    e0 = err_cnt;
    send_frame(100, 99, 2, 0);
    @(negedge clk);
    tot_cnt++; if (err_cnt - e0 !== 1) $display("FAIL short_err got %0d exp 1", err_cnt - e0); else pass_cnt++;
    tot_cnt++; if (s_ready !== 1'b1 || dbg_state !== 2'(LOAD)) $display("FAIL short_ready got r=%0b st=%0d exp r=1 st=0", s_ready, dbg_state); else pass_cnt++;
    tot_cnt++; if (nn_inputs[32*99 +: 32] !== 32'h0000_1100) $display("FAIL short_written got %h exp 00001100", nn_inputs[32*99 +: 32]); else pass_cnt++;
    tot_cnt++; if (nn_inputs[32*100 +: 32] !== 32'h0000_6400) $display("FAIL short_not_cleared got %h exp 00006400", nn_inputs[32*100 +: 32]); else pass_cnt++;
    for (int k = 0; k < NO; k++) set_score(k, 32'h0001_0000);
    set_score(5, 32'h0003_0000);
    send_frame(NI, NI-1, 0, 0);
    wait_res(lat);
    tot_cnt++; if (lat !== 15 || res_digit !== 4'd5) $display("FAIL after_short got lat=%0d d=%0d exp lat=15 d=5", lat, res_digit); else pass_cnt++;
    tot_cnt++; if (err_cnt - e0 !== 1) $display("FAIL after_short_err got %0d exp 1", err_cnt - e0); else pass_cnt++;
    @(negedge clk);
    set_score(8, 32'h7FFF_FFFF);
    send_frame(NI, -1, 1, 0);
    wait_res(lat);
    tot_cnt++; if (lat !== 15) $display("FAIL nolast_latency got %0d exp 15", lat); else pass_cnt++;
    tot_cnt++; if (err_cnt - e0 !== 2) $display("FAIL nolast_err got %0d exp 2", err_cnt - e0); else pass_cnt++;
    tot_cnt++; if (res_digit !== 4'd8 || res_score !== 32'h7FFF_FFFF) $display("FAIL nolast_result got %0d/%h exp 8/7FFFFFFF", res_digit, res_score); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    logic [32*NI-1:0] snap;
    for (int k = 0; k < NO; k++) set_score(k, 32'h0000_0100 * k);
    res_ready = 1'b0;
    send_frame(NI, NI-1, 0, 0);
    wait_res(lat);
    tot_cnt++; if (lat !== 15 || res_digit !== 4'd9) $display("FAIL bp_result got lat=%0d d=%0d exp lat=15 d=9", lat, res_digit); else pass_cnt++;
    snap = nn_inputs;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      s_valid = 1'b1; s_data = 8'($urandom); s_last = 1'($urandom);
      @(negedge clk);
      if (res_valid !== 1'b1 || res_digit !== 4'd9 || res_score !== 32'h0000_0900 ||
          s_ready !== 1'b0 || dbg_state !== 2'(DONE)) bad++;
    end
    s_valid = 1'b0; s_last = 1'b0;
    tot_cnt++; if (bad !== 0) $display("FAIL bp_hold bad_cycles=%0d exp 0", bad); else pass_cnt++;
    tot_cnt++; if (nn_inputs !== snap) $display("FAIL bp_no_accept inputs changed exp unchanged"); else pass_cnt++;
    res_ready = 1'b1;
    @(negedge clk);
    tot_cnt++; if (res_valid !== 1'b0 || s_ready !== 1'b1) $display("FAIL bp_release got v=%0b r=%0b exp v=0 r=1", res_valid, s_ready); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    for (int k = 0; k < NO; k++) set_score(k, 32'h0000_0000);
    set_score(6, 32'h0000_8000);
    send_frame(300, -1, 1, 2);
    rst_n = 1'b0;
    #1;
    tot_cnt++; if (nn_inputs !== '0 || s_ready !== 1'b0 || dbg_state !== 2'(LOAD)) $display("FAIL rstload got r=%0b st=%0d exp r=0 st=0 inputs=0", s_ready, dbg_state); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(NI, NI-1, 0, 2);
    repeat (8) @(negedge clk);
    tot_cnt++; if (dbg_state !== 2'(SCAN)) $display("FAIL rstscan_pre got %0d exp %0d", dbg_state, SCAN); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    tot_cnt++; if (res_valid !== 1'b0 || res_digit !== 4'd0 || res_score !== 32'd0 || dbg_state !== 2'(LOAD)) $display("FAIL rstscan got v=%0b d=%0d s=%h st=%0d exp all 0", res_valid, res_digit, res_score, dbg_state); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(negedge clk); if (res_valid) seen++; end
    tot_cnt++; if (seen !== 0) $display("FAIL rst_no_result got %0d exp 0", seen); else pass_cnt++;
    send_frame(NI, NI-1, 1, 2);
    wait_res(lat);
    tot_cnt++; if (lat !== 15 || res_digit !== 4'd6 || res_score !== 32'h0000_8000) $display("FAIL rst_recover got lat=%0d d=%0d s=%h exp 15/6/00008000", lat, res_digit, res_score); else pass_cnt++;
    tot_cnt++; if (count_bad(1, NI) !== 0) $display("FAIL rst_recover_inputs bad_words=%0d exp 0", count_bad(1, NI)); else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_negative();
    test_frame_err();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
